demo_pattern_gen: RTL and testbench

Parametrised demonstration stimulus source for the PuTTY/UART print path. Generates NUM_CH signed binary words on a programmable period and presents them to the downstream binary-to-ASCII and print stage with a valid/ready handshake. Supports toggle, ramp, hold and single-shot modes, and never loses the consumer's current word.

---
 rtl/demo_pattern_gen.sv | 136 +++++++++++++
 tb/tb_demo_pattern_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/demo_pattern_gen.sv
// Demo stimulus source: NUM_CH signed words per period, toggle/ramp/hold/single-shot; DEMO_PATGEN_OVERRUN_CNT_EN adds overrun_count.
// Latency: 1 cycle from tick/trigger to data_valid; backpressure: held word never lost, updates not accepted are dropped.
module demo_pattern_gen #(
    parameter int          CLK_FREQ_HZ = 100_000_000,
    parameter int          PERIOD_MS   = 1000,
    parameter int          NUM_CH      = 4,
    parameter int          DATA_W      = 20,
    parameter logic [31:0] SEED        = 32'h0002_3CE9,
    parameter logic [31:0] CH_OFFSET   = 32'd1,
    parameter logic [31:0] STEP        = 32'd1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mode,
    input  logic                     trigger,
    input  logic                     data_ready,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     data_valid,
`ifdef DEMO_PATGEN_OVERRUN_CNT_EN
    output logic [15:0]              overrun_count,
`endif
    output logic                     tick
);

    localparam int TICKS = CLK_FREQ_HZ / 1000 * PERIOD_MS;
    localparam int CNT_W = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

    function automatic logic [NUM_CH-1:0][DATA_W-1:0] init_base();
        logic [NUM_CH-1:0][DATA_W-1:0] b;
        logic [31:0]                   v;
        for (int i = 0; i < NUM_CH; i++) begin
            v    = SEED + CH_OFFSET * 32'(i);
            b[i] = v[DATA_W-1:0];
        end
        return b;
    endfunction

    localparam logic [NUM_CH-1:0][DATA_W-1:0] BASE = init_base();
    localparam logic [DATA_W-1:0] STEP_W = STEP[DATA_W-1:0];

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      tick_q, tick_d;
    logic [NUM_CH*DATA_W-1:0]  data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      phase_q, phase_d;
    logic                      armed_q, armed_d;
    logic [1:0]                last_mode_q, last_mode_d;
    logic                      upd_ev, xfer, accept, eff_phase;

    always_comb begin
        cnt_d       = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        tick_d      = (cnt_d == LAST);
        upd_ev      = (mode == 2'd3) ? (trigger && armed_q) : tick_q;
        xfer        = valid_q && data_ready;
        accept      = upd_ev && (!valid_q || xfer);
        armed_d     = armed_q;
        data_d      = data_q;
        valid_d     = valid_q && !xfer;
        phase_d     = phase_q;
        last_mode_d = last_mode_q;
        // Coming back from ramp/hold always restarts the toggle on the positive base.
        eff_phase   = phase_q && !(last_mode_q == 2'd1 || last_mode_q == 2'd2);

        if (!trigger) begin
            armed_d = 1'b1;
        end else if (mode == 2'd3 && armed_q) begin
            armed_d = 1'b0;
        end

        if (accept) begin
            valid_d     = 1'b1;
            last_mode_d = mode;
            case (mode)
                2'd0, 2'd3: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        data_d[i*DATA_W +: DATA_W] = eff_phase ? (~BASE[i] + 1'b1) : BASE[i];
                    end
                    phase_d = !eff_phase;
                end
                2'd1: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        data_d[i*DATA_W +: DATA_W] = data_q[i*DATA_W +: DATA_W] + STEP_W;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            phase_q     <= 1'b0;
            armed_q     <= 1'b1;
            last_mode_q <= 2'd0;
        end else begin
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            phase_q     <= phase_d;
            armed_q     <= armed_d;
            last_mode_q <= last_mode_d;
        end
    end

`ifdef DEMO_PATGEN_OVERRUN_CNT_EN
    logic [15:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (upd_ev && !accept && ovr_q != 16'hFFFF) begin
            ovr_d = ovr_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_count = ovr_q;
`endif

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_demo_pattern_gen.sv
// Randomised and directed bench for demo_pattern_gen against a cycle-count based reference model.
module tb_demo_pattern_gen;
    localparam int TICKS = 10;
    localparam int NCH   = 4;
    localparam int DW    = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              trigger = 1'b0;
    logic              data_ready = 1'b0;
    logic [NCH*DW-1:0] data_out, w_data;
    logic              data_valid, tick, w_valid, w_tick;
`ifdef DEMO_PATGEN_OVERRUN_CNT_EN
    logic [15:0]       overrun_count, w_ovr;
`endif

    always #5 clk = ~clk;

    demo_pattern_gen #(
        .CLK_FREQ_HZ(1000), .PERIOD_MS(10), .NUM_CH(NCH), .DATA_W(DW),
        .SEED(32'h0002_3CE9), .CH_OFFSET(32'd1), .STEP(32'd1)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .trigger(trigger),
        .data_ready(data_ready), .data_out(data_out), .data_valid(data_valid),
`ifdef DEMO_PATGEN_OVERRUN_CNT_EN
        .overrun_count(overrun_count),
`endif
        .tick(tick)
    );

    demo_pattern_gen #(
        .CLK_FREQ_HZ(1000), .PERIOD_MS(10), .NUM_CH(NCH), .DATA_W(DW),
        .SEED(32'h0002_3CE9), .CH_OFFSET(32'd1), .STEP(32'h000F_FFFF)
    ) dut_w (
        .clk(clk), .reset(reset), .mode(2'd1), .trigger(1'b0),
        .data_ready(1'b1), .data_out(w_data), .data_valid(w_valid),
`ifdef DEMO_PATGEN_OVERRUN_CNT_EN
        .overrun_count(w_ovr),
`endif
        .tick(w_tick)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference model state: the period position comes from a plain cycle count.
    int              m_cyc;
    bit              m_valid, m_armed, m_phase;
    int              m_last_mode;
    logic [DW-1:0]   m_word [NCH];
    int              m_ovr;

    function automatic logic [DW-1:0] base(input int i);
        return DW'(32'h0002_3CE9 + i);
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_valid = 0; m_armed = 1; m_phase = 0; m_last_mode = 0; m_ovr = 0;
        for (int i = 0; i < NCH; i++) m_word[i] = '0;
    endtask

    task automatic step(input logic [1:0] md, input bit tr, input bit rd);
        bit tk, ev, xf, acc;
        logic [DW-1:0] wexp;
        @(negedge clk);
        tk = (m_cyc % TICKS) == TICKS - 1;
        chk("tick", 32'(tick), 32'(tk));
        chk("valid", 32'(data_valid), 32'(m_valid));
        for (int i = 0; i < NCH; i++) chk("data", 32'(data_out[i*DW +: DW]), 32'(m_word[i]));
`ifdef DEMO_PATGEN_OVERRUN_CNT_EN
        chk("overrun", 32'(overrun_count), 32'(m_ovr));
`endif
        // Wrap instance: k-th word is k*FFFFF = -k mod 2^20 on every channel.
        wexp = DW'(0 - (m_cyc / TICKS));
        chk("wrap_vld", 32'(w_valid), 32'(m_cyc > 0 && (m_cyc % TICKS) == 0));
        chk("wrap_ch0", 32'(w_data[0 +: DW]), 32'(wexp));
        chk("wrap_ch3", 32'(w_data[3*DW +: DW]), 32'(wexp));
        chk("wrap_nox", 32'($isunknown(w_data)), 32'd0);

        mode = md; trigger = tr; data_ready = rd;

        ev  = (md == 2'd3) ? (tr && m_armed) : tk;
        xf  = m_valid && rd;
        acc = ev && (!m_valid || xf);
        if (md == 2'd3 && tr && m_armed) m_armed = 0;
        else if (!tr) m_armed = 1;
        if (ev && !acc && m_ovr < 65535) m_ovr++;
        if (xf) m_valid = 0;
        if (acc) begin
            m_valid = 1;
            if (md == 2'd0 || md == 2'd3) begin
                if (m_last_mode == 1 || m_last_mode == 2) m_phase = 0;
                for (int i = 0; i < NCH; i++) m_word[i] = m_phase ? (DW'(0) - base(i)) : base(i);
                m_phase = !m_phase;
            end else if (md == 2'd1) begin
                for (int i = 0; i < NCH; i++) m_word[i] = m_word[i] + DW'(1);
            end
            m_last_mode = int'(md);
        end
        m_cyc++;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; mode = 2'd0; trigger = 1'b0; data_ready = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int nv, nt;
        logic [DW-1:0] cap;
        logic [1:0] md;
        bit tr, rd;

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_data", 32'(|data_out), 32'd0);
        release_reset();

        // Toggle, consumer always ready.
        repeat (11) step(2'd0, 1'b0, 1'b1);
        chk("first_vld", 32'(data_valid), 32'd1);
        chk("first_ch0", 32'(data_out[0 +: DW]), 32'h23CE9);
        chk("first_ch3", 32'(data_out[3*DW +: DW]), 32'h23CEC);
        repeat (10) step(2'd0, 1'b0, 1'b1);
        chk("second_ch0", 32'(data_out[0 +: DW]), 32'hDC317);

        // Ramp with a stalled consumer for three periods.
        apply_reset();
        repeat (31) step(2'd1, 1'b0, 1'b0);
        chk("hold_ch0", 32'(data_out[0 +: DW]), 32'h00001);
        chk("hold_ch2", 32'(data_out[2*DW +: DW]), 32'h00001);
`ifdef DEMO_PATGEN_OVERRUN_CNT_EN
        chk("hold_ovr", 32'(overrun_count), 32'd2);
`endif
        repeat (9) step(2'd1, 1'b0, 1'b1);
        step(2'd1, 1'b0, 1'b0);
        chk("ramp2_ch0", 32'(data_out[0 +: DW]), 32'h00002);

        // Transfer in the same cycle as the tick.
        repeat (8) step(2'd1, 1'b0, 1'b0);
        step(2'd1, 1'b0, 1'b1);
        step(2'd1, 1'b0, 1'b0);
        chk("coin_vld", 32'(data_valid), 32'd1);
        chk("coin_ch0", 32'(data_out[0 +: DW]), 32'h00003);
`ifdef DEMO_PATGEN_OVERRUN_CNT_EN
        chk("coin_ovr", 32'(overrun_count), 32'd2);
`endif

        // Single shot: level trigger gives one word per arm.
        repeat (2) step(2'd3, 1'b0, 1'b1);
        nv = 0; nt = 0; cap = '0;
        repeat (50) begin
            step(2'd3, 1'b1, 1'b1);
            if (data_valid) begin nv++; cap = data_out[0 +: DW]; end
            if (tick) nt++;
        end
        chk("ss_words", 32'(nv), 32'd1);
        chk("ss_ticks", 32'(nt), 32'd5);
        chk("ss_ch0", 32'(cap), 32'h23CE9);
        repeat (3) step(2'd3, 1'b0, 1'b1);
        nv = 0; cap = '0;
        repeat (10) begin
            step(2'd3, 1'b1, 1'b1);
            if (data_valid) begin nv++; cap = data_out[0 +: DW]; end
        end
        chk("ss2_words", 32'(nv), 32'd1);
        chk("ss2_ch0", 32'(cap), 32'hDC317);

        // Random traffic with bursty ready/trigger and occasional mode changes.
        apply_reset();
        md = 2'd0; tr = 0; rd = 1;
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) tr = !tr;
            if ($urandom_range(0, 5) == 0) rd = !rd;
            step(md, tr, rd);
        end

        // Async reset while a word is pending.
        repeat (12) step(2'd2, 1'b0, 1'b0);
        chk("pre_rst_vld", 32'(data_valid), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(data_valid), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_data", 32'(|data_out), 32'd0);
        chk("arst_wdata", 32'(|w_data), 32'd0);
`ifdef DEMO_PATGEN_OVERRUN_CNT_EN
        chk("arst_ovr", 32'(overrun_count), 32'd0);
`endif
        mode = 2'd0; trigger = 1'b0; data_ready = 1'b0;
        release_reset();
        repeat (25) step(2'd0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
